fir_checkbits_soc: RTL and testbench
====================================

# fir_checkbits_soc

Self-contained FIR benchmark engine with a GPIO status sequencer, standing in for the user-project FIR inside the Caravel harness. After reset it runs an 11-tap FIR over a 64-sample ramp three times. It reports progress on a 16-bit checkbits bus (mapped to mprj_io[31:16]) using fixed marker codes, and can optionally send each result byte on a UART line (mprj_io[6]).

## Interface
Parameters:
- DATA_LEN, 64: samples per iteration.
- NUM_ITER, 3: number of FIR iterations.
- HOLD_CYCLES, 16: cycles each marker is held (AB40, result).
- BAUD_DIV, 16: clocks per UART bit; must be at least 2.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- checkbits, out, 16: status and marker bus.
- uart_tx, out, 1: serial TX, idle high.
- done, out, 1: high once all iterations are finished.

## Operation
- Taps h[0..10] = {0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0}, signed 32-bit.
- Input x[m] = m for 0 ≤ m < DATA_LEN; x[m] = 0 for m < 0.
- Output y[n] = Σk h[k]·x[n−k], computed with a 32-bit two's-complement accumulator.
  - Products and sums wrap modulo 2^32.
- Only y[DATA_LEN−1] is retained. With the defaults it equals 10614 = 0x2976.
- Sequencer states, in order:
  - IDLE: 1 cycle after reset deasserts.
  - ANNOUNCE: checkbits = 0xAB40 for HOLD_CYCLES cycles.
  - START: 1 cycle. checkbits = 0x00A5. Clears acc, n = 0, k = 0.
  - MAC: checkbits stays 0x00A5. Each cycle performs acc += h[k]·x[n−k].
    - When k = 10: latch y = acc + product, clear acc, set k = 0, increment n.
    - Otherwise increment k.
    - Leaves MAC after n = DATA_LEN−1, k = 10.
  - RESULT: checkbits = {y[7:0], 8'h5A}.
    - Held for HOLD_CYCLES cycles. When STATUS_UART_EN is defined, also held until the UART frame completes, whichever is later.
    - Then increment the iteration counter: go to START if iterations < NUM_ITER, otherwise DONE.
  - DONE: checkbits = 0xAB51, done = 1. Held until reset.
- Every iteration produces the same result (0x765A with the defaults).

## Timing
- Reset values: checkbits = 0x0000, uart_tx = 1, done = 0. acc, n, k and the iteration counter are all 0. State = IDLE.
- Reset asserted at any point, including mid-MAC or mid-UART-frame: all state returns to reset values on the next edge and no partial result is ever shown.
- ANNOUNCE first appears 2 cycles after the reset-release edge.
- Iteration latency: 0x5A first appears DATA_LEN·11 + 1 cycles after the first 0xA5 cycle. With the defaults this is 705 cycles.
- The low byte is never 0x5A while in START or MAC, and never 0xA5 while in RESULT.
- All outputs are registered.
- Total run with the defaults and UART disabled: 2 + 16 + 3·(705 + 16) cycles to reach DONE.

## Configuration
- STATUS_UART_EN defined:
  - On RESULT entry, transmit y[7:0] as 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
  - Each bit lasts BAUD_DIV cycles; the frame is 10·BAUD_DIV cycles.
  - RESULT holds until the stop bit completes.
- STATUS_UART_EN undefined:
  - uart_tx is tied to 1 and the UART logic is absent.
  - RESULT lasts exactly HOLD_CYCLES cycles.

## Structure
- Shared package fir_checkbits_pkg:
  - Tap ROM constant.
  - Marker constants: 16'hAB40, 8'hA5, 8'h5A, 16'hAB51.
  - Sequencer state enum.
- One sub-module: uart_tx_8n1 (inputs clock, reset, start, data[7:0]; outputs tx, busy). It is instantiated only under STATUS_UART_EN.
- The MAC datapath and the sequencer live in the top module.

## Test plan
- Reset, then release -> checkbits 0x0000 during reset; 0xAB40 from cycle 2 for 16 cycles.
- Iteration 1 -> 0x00A5 held for 705 cycles, then 0x765A for 16 cycles; internal y = 0x00002976.
- Iterations 2 and 3 -> each gives 705-cycle latency and 0x765A; then 0xAB51 with done = 1, stable for 1000 or more cycles.
- Reset asserted mid-MAC of iteration 2 -> next edge gives checkbits = 0, done = 0; the full sequence restarts and reproduces 0x765A.
- STATUS_UART_EN with BAUD_DIV = 16 -> uart_tx carries 0x76 (bits 0,1,1,0,1,1,1,0,1 LSB first after the start bit) in a 160-cycle frame; RESULT lasts 160 cycles.
- DATA_LEN = 1 -> y = 0, checkbits = 0x005A, latency 12 cycles.

Source files
------------

// File: rtl/fir_checkbits_pkg.sv
// fir_checkbits_pkg: tap ROM, marker codes and sequencer states
// shared by the fir_checkbits_soc benchmark engine.
package fir_checkbits_pkg;

  localparam int NTAPS = 11;

  localparam logic [15:0] MK_ANNOUNCE = 16'hAB40;
  localparam logic [7:0]  MK_START    = 8'hA5;
  localparam logic [7:0]  MK_RESULT   = 8'h5A;
  localparam logic [15:0] MK_DONE     = 16'hAB51;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANNOUNCE,
    S_START,
    S_MAC,
    S_RESULT,
    S_DONE
  } seq_state_e;

  // Symmetric low-pass taps, signed 32-bit
  function automatic logic [31:0] tap(input logic [3:0] k);
    case (k)
      4'd1, 4'd9: tap = 32'hFFFF_FFF6;
      4'd2, 4'd8: tap = 32'hFFFF_FFF7;
      4'd3, 4'd7: tap = 32'd23;
      4'd4, 4'd6: tap = 32'd56;
      4'd5:       tap = 32'd63;
      default:    tap = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/fir_checkbits_soc_uart.sv
// uart_tx_8n1: 8N1 serial transmitter, LSB first, idle high.
// A frame is 10*BAUD_DIV cycles; busy covers the whole frame.
module uart_tx_8n1
  import fir_checkbits_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  logic [9:0]  r_sh;
  logic [15:0] r_div;
  logic [3:0]  r_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx    <= 1'b1;
      busy  <= 1'b0;
      r_sh  <= '1;
      r_div <= '0;
      r_bit <= '0;
    end else if (!busy) begin
      if (start) begin
        r_sh  <= {1'b1, data, 1'b0};
        tx    <= 1'b0;
        busy  <= 1'b1;
        r_div <= '0;
        r_bit <= '0;
      end
    end else if (r_div == 16'(BAUD_DIV - 1)) begin
      r_div <= '0;
      if (r_bit == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        r_bit <= r_bit + 4'd1;
        r_sh  <= {1'b1, r_sh[9:1]};
        tx    <= r_sh[1];
      end
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

endmodule

// File: rtl/fir_checkbits_soc.sv
// fir_checkbits_soc: 11-tap FIR over a ramp with a checkbits marker sequencer.
// Define STATUS_UART_EN to also send each result byte on uart_tx.
module fir_checkbits_soc
  import fir_checkbits_pkg::*;
#(
  parameter int DATA_LEN    = 64,
  parameter int NUM_ITER    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int BAUD_DIV    = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] checkbits,
  output logic        uart_tx,
  output logic        done
);

`ifdef STATUS_UART_EN
  localparam int FRAME_LEN = 10 * BAUD_DIV;
  localparam int RES_LEN   =
    (HOLD_CYCLES > FRAME_LEN) ? HOLD_CYCLES : FRAME_LEN;
`else
  localparam int RES_LEN = HOLD_CYCLES;
`endif

  seq_state_e  r_state;
  logic [31:0] r_acc;
  logic [31:0] r_y;
  logic [15:0] r_n;
  logic [15:0] r_cnt;
  logic [3:0]  r_k;
  logic [7:0]  r_iter;

  logic [31:0] w_x;
  logic [31:0] w_prod;
  logic [31:0] w_sum;
  logic        w_last_tap;
  logic        w_last_n;

  // Ramp input with zero history before the first sample
  assign w_x = (r_n >= {12'd0, r_k}) ?
               {16'd0, r_n - {12'd0, r_k}} : 32'd0;
  assign w_prod     = tap(r_k) * w_x;
  assign w_sum      = r_acc + w_prod;
  assign w_last_tap = (r_k == 4'(NTAPS - 1));
  assign w_last_n   = (r_n == 16'(DATA_LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_y       <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_iter    <= '0;
      checkbits <= '0;
      done      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          checkbits <= '0;
          r_cnt     <= '0;
          r_state   <= S_ANNOUNCE;
        end
        S_ANNOUNCE: begin
          checkbits <= MK_ANNOUNCE;
          r_cnt     <= r_cnt + 16'd1;
          if (r_cnt == 16'(HOLD_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          checkbits <= {8'h00, MK_START};
          r_acc     <= '0;
          r_n       <= '0;
          r_k       <= '0;
          r_state   <= S_MAC;
        end
        S_MAC: begin
          checkbits <= {8'h00, MK_START};
          if (w_last_tap) begin
            r_y   <= w_sum;
            r_acc <= '0;
            r_k   <= '0;
            r_n   <= r_n + 16'd1;
            if (w_last_n) begin
              r_cnt   <= '0;
              r_state <= S_RESULT;
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 4'd1;
          end
        end
        S_RESULT: begin
          checkbits <= {r_y[7:0], MK_RESULT};
          r_cnt     <= r_cnt + 16'd1;
          if (r_cnt == 16'(RES_LEN - 1)) begin
            r_cnt   <= '0;
            r_iter  <= r_iter + 8'd1;
            r_state <= (r_iter == 8'(NUM_ITER - 1)) ?
                       S_DONE : S_START;
          end
        end
        S_DONE: begin
          checkbits <= MK_DONE;
          done      <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STATUS_UART_EN
  logic r_uart_go;
  logic w_busy;

  // Fire once, aligned with the first cycle the result is shown
  always_ff @(posedge clock) begin
    if (reset) r_uart_go <= 1'b0;
    else       r_uart_go <= (r_state == S_MAC) && w_last_tap &&
                            w_last_n && !w_busy;
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clock (clock),
    .reset (reset),
    .start (r_uart_go),
    .data  (r_y[7:0]),
    .tx    (uart_tx),
    .busy  (w_busy)
  );
`else
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_fir_checkbits_soc.sv
// Self-checking bench for fir_checkbits_soc: default build and DATA_LEN=1,
// timeline reference model, marker table and randomized mid-run resets.
module tb_fir_checkbits_soc;

  localparam int HOLD = 16;
  localparam int BAUD = 16;
  localparam int NIT  = 3;
  localparam int L0   = 64;
  localparam int L1   = 1;
`ifdef STATUS_UART_EN
  localparam int RES     = (HOLD > 10 * BAUD) ? HOLD : 10 * BAUD;
  localparam bit UART_ON = 1'b1;
`else
  localparam int RES     = HOLD;
  localparam bit UART_ON = 1'b0;
`endif
  localparam int P0 = L0 * 11 + 1 + RES;
  localparam int T0 = 2 + HOLD + NIT * P0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cb0, cb1;
  logic        tx0, tx1, dn0, dn1;

  int errors = 0;
  int checks = 0;

  int H [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  logic [31:0] yw0, yw1;
  logic [7:0]  y0, y1;
  logic [15:0] tr [0:4095];

  typedef struct {
    int          k;
    logic [15:0] cb;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  fir_checkbits_soc #(
    .DATA_LEN(L0), .NUM_ITER(NIT), .HOLD_CYCLES(HOLD), .BAUD_DIV(BAUD)
  ) u_dut (
    .clock(clk), .reset(rst), .checkbits(cb0), .uart_tx(tx0), .done(dn0)
  );

  fir_checkbits_soc #(
    .DATA_LEN(L1), .NUM_ITER(NIT), .HOLD_CYCLES(HOLD), .BAUD_DIV(BAUD)
  ) u_dut1 (
    .clock(clk), .reset(rst), .checkbits(cb1), .uart_tx(tx1), .done(dn1)
  );

  // y[L-1] straight from the convolution sum
  function automatic logic [31:0] ref_y(int L);
    logic [31:0] acc;
    int n;
    acc = 32'd0;
    n = L - 1;
    for (int k = 0; k < 11; k++)
      if (n - k >= 0) acc = acc + 32'(H[k] * (n - k));
    return acc;
  endfunction

  // {done, checkbits} expected k cycles after reset release
  function automatic logic [16:0] exp_out(int k, int L, logic [7:0] y);
    int p, o;
    p = L * 11 + 1 + RES;
    if (k < 2) return {1'b0, 16'h0000};
    if (k < 2 + HOLD) return {1'b0, 16'hAB40};
    o = k - (2 + HOLD);
    if (o >= NIT * p) return {1'b1, 16'hAB51};
    o = o % p;
    if (o <= L * 11) return {1'b0, 16'h00A5};
    return {1'b0, y, 8'h5A};
  endfunction

  function automatic logic exp_tx(int k, int L, logic [7:0] y);
    int p, o;
    logic [9:0] fr;
    p = L * 11 + 1 + RES;
    fr = {1'b1, y, 1'b0};
    if (!UART_ON || k < 2 + HOLD) return 1'b1;
    o = k - (2 + HOLD);
    if (o >= NIT * p) return 1'b1;
    o = (o % p) - (L * 11 + 1);
    if (o < 0 || o >= 10 * BAUD) return 1'b1;
    return fr[o / BAUD];
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int kmax);
    logic [16:0] e0, e1;
    for (int k = 1; k <= kmax; k++) begin
      tick();
      e0 = exp_out(k, L0, y0);
      e1 = exp_out(k, L1, y1);
      if (k < 4096) tr[k] = cb0;
      chk("cb0", k, 32'(cb0), 32'(e0[15:0]));
      chk("done0", k, 32'(dn0), 32'(e0[16]));
      chk("cb1", k, 32'(cb1), 32'(e1[15:0]));
      chk("done1", k, 32'(dn1), 32'(e1[16]));
      chk("tx0", k, 32'(tx0), 32'(exp_tx(k, L0, y0)));
      chk("tx1", k, 32'(tx1), 32'(exp_tx(k, L1, y1)));
    end
  endtask

  task automatic chk_reset(int k);
    chk("rst_cb0", k, 32'(cb0), 32'h0);
    chk("rst_done0", k, 32'(dn0), 32'h0);
    chk("rst_tx0", k, 32'(tx0), 32'h1);
    chk("rst_cb1", k, 32'(cb1), 32'h0);
  endtask

  initial begin
    int kab, hold;
    yw0 = ref_y(L0);
    yw1 = ref_y(L1);
    y0 = yw0[7:0];
    y1 = yw1[7:0];

    tbl.push_back('{k: 1, cb: 16'h0000});
    tbl.push_back('{k: 2, cb: 16'hAB40});
    tbl.push_back('{k: 17, cb: 16'hAB40});
    tbl.push_back('{k: 18, cb: 16'h00A5});
    tbl.push_back('{k: 18 + 704, cb: 16'h00A5});
    tbl.push_back('{k: 18 + 705, cb: 16'h765A});
    tbl.push_back('{k: 18 + P0 - 1, cb: 16'h765A});
    tbl.push_back('{k: 18 + P0, cb: 16'h00A5});
    tbl.push_back('{k: 18 + P0 + 705, cb: 16'h765A});
    tbl.push_back('{k: 18 + 2 * P0 + 704, cb: 16'h00A5});
    tbl.push_back('{k: 18 + 3 * P0 - 1, cb: 16'h765A});
    tbl.push_back('{k: 18 + 3 * P0, cb: 16'hAB51});
    tbl.push_back('{k: 18 + 3 * P0 + 999, cb: 16'hAB51});

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset(-1);
    end
    rst = 1'b0;
    run(T0 + 1000);

    foreach (tbl[i])
      chk("table", tbl[i].k, 32'(tr[tbl[i].k]), 32'(tbl[i].cb));
    chk("y_int", T0, u_dut.r_y, 32'h0000_2976);
    chk("y1_int", T0, u_dut1.r_y, 32'h0);

    for (int t = 0; t < 2; t++) begin
      rst = 1'b1;
      tick();
      chk_reset(0);
      rst = 1'b0;
      kab = $urandom_range(18 + P0 + 1, 18 + P0 + L0 * 11);
      run(kab);
      rst = 1'b1;
      tick();
      chk_reset(kab + 1);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk_reset(kab + 2 + i);
      end
      rst = 1'b0;
      run(T0 + 20);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
